line_window_buffer: RTL
=======================

Name: line_window_buffer

Overview:
- Parametrised, multi-tap successor to the single fixed 76x32 line RAM in the edge-detector pixel path.
- Accepts one pixel per valid cycle in raster order.
- Presents the current pixel plus the same-column pixel from each of the previous TAPS lines, aligned on one cycle, to feed the 3x3 (or larger) convolution window.
- Uses rotating line RAMs, so every RAM uses a single shared address.

Parameters:
- WIDTH, 32, bits per pixel word
- DEPTH, 76, pixels per line (RAM depth); must be >= 2
- TAPS, 2, number of delayed lines output; must be >= 1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  pixel accepted this cycle
- in_data  in  WIDTH  pixel
- out_valid  out  1  out_* and tap_data valid
- out_data  out  WIDTH  in_data delayed 1 cycle
- tap_data  out  TAPS*WIDTH  slice k-1 = pixel k lines earlier, same column
- out_col  out  clog2(DEPTH)  column of the out_data pixel
- out_eol  out  1  out_col == DEPTH-1
- primed  out  1  all TAPS lines hold real data

Behaviour:
- Reset values: col=0, wsel=0, lines_done=0. Outputs: out_valid=0, out_data=0, out_col=0, out_eol=0, primed=0. RAM contents are not reset.
- Storage: TAPS read-first RAMs, DEPTH x WIDTH. All RAMs read address col every accepted cycle. Only RAM[wsel] is written, with in_data at col. Its registered read returns the pre-write value.
- Latency: exactly 1 cycle from accept to out_valid/out_data/tap_data/out_col.
- in_valid=0: no RAM write, col/wsel hold, out_valid=0 next cycle. Other outputs hold their last values. Stalls of any length are allowed.
- Column counter: increments on accept. At DEPTH-1 it wraps to 0 (no out-of-range address; non-power-of-2 DEPTH supported).
- Line rotation: on accept with col==DEPTH-1, wsel <= (wsel+1) mod TAPS and lines_done saturating-increments to TAPS.
- Tap mapping: RAM (wsel+j) mod TAPS, j=0..TAPS-1, drives tap TAPS-j. Tap TAPS is the row being overwritten. wsel is registered alongside the read data so the output mux uses the accept-cycle wsel.
- primed: registered; 1 once lines_done==TAPS, as seen by the first output of line TAPS. Stays 1 until rst.
- out_eol asserts with the last pixel of every line.
- rst mid-line: counters and flags clear next edge. In-flight output is dropped (out_valid=0). RAM keeps stale data; primed=0 until TAPS full lines are re-accepted.
- rst and in_valid in the same cycle: rst wins, no RAM write.
- Widths: col/out_col are clog2(DEPTH) bits; lines_done is clog2(TAPS+1) bits; wsel is clog2(TAPS) bits (min 1).

Optional Feature:
- Macro LINEBUF_ZERO_FILL_EN.
- Defined: a per-tap valid register is cleared by rst. Bit k is set at the line wrap where lines_done reaches k. While clear, that tap slice outputs 0 instead of RAM data, so the first image rows see zero padding.
- Undefined: taps always output raw RAM data (X/stale before priming). The consumer must gate on primed.
- out_valid and primed timing are identical in both builds.

Decomposition:
- Package linebuf_pkg: clog2 helper function, address-width and wsel-width derivation constants, tap slice index macros/functions.
- Sub-module line_ram: parametrised WIDTH/DEPTH single-port read-first synchronous RAM (write_en, addr, wr_data, registered rd_data), instantiated TAPS times via generate.
- Top holds the counters, the rotation, the output mux and the flags.

Test Plan (WIDTH=8, DEPTH=4, TAPS=2 unless noted):
- Reset then stream 0x00..0x0B continuously. Pixel 0x08 → out_data=0x08, tap1=0x04, tap2=0x00, primed=1, out_col=0. Pixel 0x0B → out_eol=1, tap1=0x07, tap2=0x03.
- Same stream with in_valid toggling 1/0 → outputs identical to the continuous run on valid cycles only. out_valid=0 on gaps; col does not advance on gaps.
- DEPTH=5 (non-power-of-2): 15 pixels 0..14 → out_col sequence 0,1,2,3,4,0…; pixel 10 gives tap1=5, tap2=0.
- Assert rst after pixel 0x06 and restart from 0x20 → out_valid=0 for the reset cycle, out_col restarts at 0, primed=0 until pixel 0x28.
- LINEBUF_ZERO_FILL_EN defined, RAM preloaded with 0xFF: first line → tap1=tap2=0. Second line → tap1=line 0 data, tap2=0. Third line → both taps real.
- rst asserted together with in_valid and data 0xAA → no write: a later read of that address never returns 0xAA, and the next cycle has out_valid=0.

Source files
------------

// File: rtl/linebuf_pkg.sv
// linebuf_pkg: width helpers and tap slice helpers shared by the line window buffer.
// Build option: LINEBUF_ZERO_FILL_EN (see line_window_buffer.sv).
package linebuf_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 76;
  localparam int DEF_TAPS  = 2;

  // Ceiling log2 for elaboration-time width derivation (clog2(1) = 0).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r = r + 1;
    return r;
  endfunction

  // Column / RAM address width; at least one bit.
  function automatic int addr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // Write-select width; a single-tap build still gets a one-bit register.
  function automatic int wsel_width(input int taps);
    return (clog2(taps) < 1) ? 1 : clog2(taps);
  endfunction

  // Completed-line counter width, able to hold the value TAPS.
  function automatic int ldone_width(input int taps);
    return clog2(taps + 1);
  endfunction

  // Low bit of tap k (k = 1..TAPS) inside the packed tap_data bus.
  function automatic int tap_lo(input int tap, input int width);
    return (tap - 1) * width;
  endfunction

endpackage

// File: rtl/line_ram.sv
// line_ram: single-port read-first synchronous RAM, one line of pixels.
// The read port is registered and returns the contents before a same-cycle write.
module line_ram
  import linebuf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic             write_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Read-first port: old word is captured in the same edge the new one is stored.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem[addr];
    end
    if (write_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/line_window_buffer.sv
// line_window_buffer: raster pixel stream in, current pixel plus the same-column
// pixel from each of the previous TAPS lines out, all aligned one cycle later.
// TAPS line RAMs rotate: one is written per line, all share the column address.
// Build option LINEBUF_ZERO_FILL_EN: taps read as zero until their line exists.
module line_window_buffer
  import linebuf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAPS  = DEF_TAPS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [TAPS*WIDTH-1:0]        tap_data,
  output logic [addr_width(DEPTH)-1:0] out_col,
  output logic                         out_eol,
  output logic                         primed
);

  localparam int AW = addr_width(DEPTH);
  localparam int WW = wsel_width(TAPS);
  localparam int LW = ldone_width(TAPS);

  logic              accept;
  logic              last_col;

  logic [AW-1:0]     col_q, col_d;
  logic [WW-1:0]     wsel_q, wsel_d;
  logic [LW-1:0]     lines_done_q, lines_done_d;
  logic              primed_q, primed_d;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [AW-1:0]     out_col_q, out_col_d;
  logic              out_eol_q, out_eol_d;
  logic [WW-1:0]     rd_wsel_q, rd_wsel_d;

  logic [WIDTH-1:0]  ram_rd [TAPS];

  // Reset wins over a same-cycle pixel, so nothing is written or counted.
  assign accept   = in_valid & ~rst;
  assign last_col = (col_q == AW'(DEPTH - 1));

  // Column counter, line rotation, completed-line count and sticky primed flag.
  always_comb begin
    col_d        = col_q;
    wsel_d       = wsel_q;
    lines_done_d = lines_done_q;
    primed_d     = primed_q;
    if (accept) begin
      col_d = last_col ? '0 : col_q + AW'(1);
      if (lines_done_q == LW'(TAPS)) begin
        primed_d = 1'b1;
      end
      if (last_col) begin
        wsel_d = (wsel_q == WW'(TAPS - 1)) ? '0 : wsel_q + WW'(1);
        if (lines_done_q != LW'(TAPS)) begin
          lines_done_d = lines_done_q + LW'(1);
        end
      end
    end
  end

  // Output stage: capture the accepted pixel and the wsel that steers the tap mux.
  always_comb begin
    out_valid_d = accept;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    out_eol_d   = out_eol_q;
    rd_wsel_d   = rd_wsel_q;
    if (accept) begin
      out_data_d = in_data;
      out_col_d  = col_q;
      out_eol_d  = last_col;
      rd_wsel_d  = wsel_q;
    end
  end

  // State register; RAM contents and RAM read registers are deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      wsel_q       <= '0;
      lines_done_q <= '0;
      primed_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_col_q    <= '0;
      out_eol_q    <= 1'b0;
      rd_wsel_q    <= '0;
    end else begin
      col_q        <= col_d;
      wsel_q       <= wsel_d;
      lines_done_q <= lines_done_d;
      primed_q     <= primed_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_col_q    <= out_col_d;
      out_eol_q    <= out_eol_d;
      rd_wsel_q    <= rd_wsel_d;
    end
  end

`ifdef LINEBUF_ZERO_FILL_EN
  logic [TAPS-1:0] tap_vld_q, tap_vld_d;
  logic [TAPS-1:0] tap_ok_q, tap_ok_d;

  // Bit k-1 marks that tap k has a real line behind it; tap_ok is its accept-time copy.
  always_comb begin
    tap_vld_d = tap_vld_q;
    tap_ok_d  = tap_ok_q;
    if (accept) begin
      tap_ok_d = tap_vld_q;
      if (last_col) begin
        for (int i = 0; i < TAPS; i++) begin
          if (lines_done_q == LW'(i)) begin
            tap_vld_d[i] = 1'b1;
          end
        end
      end
    end
  end

  // Tap-valid registers, cleared by reset so a fresh image starts zero-padded.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_vld_q <= '0;
      tap_ok_q  <= '0;
    end else begin
      tap_vld_q <= tap_vld_d;
      tap_ok_q  <= tap_ok_d;
    end
  end
`endif

  genvar gi;

  // One line RAM per tap; only the RAM selected by wsel takes the new pixel.
  for (gi = 0; gi < TAPS; gi++) begin : g_ram
    line_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_line_ram (
      .clk      (clk),
      .rd_en    (accept),
      .write_en (accept && (wsel_q == WW'(gi))),
      .addr     (col_q),
      .wr_data  (in_data),
      .rd_data  (ram_rd[gi])
    );
  end

  // Tap gi+1 is read from RAM (rd_wsel + TAPS-1-gi) mod TAPS; tap TAPS is the overwritten row.
  for (gi = 0; gi < TAPS; gi++) begin : g_tap
    logic [WW:0]      src_sum;
    logic [WW:0]      src_idx;
    logic [WIDTH-1:0] raw;

    // Wrap the rotated RAM index back into 0..TAPS-1 with one conditional subtract.
    always_comb begin
      src_sum = {1'b0, rd_wsel_q} + (WW + 1)'(TAPS - 1 - gi);
      src_idx = (src_sum >= (WW + 1)'(TAPS)) ? src_sum - (WW + 1)'(TAPS) : src_sum;
      raw     = ram_rd[src_idx];
    end

`ifdef LINEBUF_ZERO_FILL_EN
    assign tap_data[tap_lo(gi + 1, WIDTH) +: WIDTH] = tap_ok_q[gi] ? raw : '0;
`else
    assign tap_data[tap_lo(gi + 1, WIDTH) +: WIDTH] = raw;
`endif
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_col   = out_col_q;
  assign out_eol   = out_eol_q;
  assign primed    = primed_q;

endmodule
